// File: rtl/addx_accel_fu_if.sv
// Issue and writeback bundle for the ADDX shift-add functional unit.
// Signal names follow the functional unit's port list; "slave" is the FU side.
interface addx_accel_fu_if #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) ();
  logic                     issue_valid_i;
  logic                     issue_ready_o;
  logic [1:0]               op_i;
  logic                     word_i;
  logic [XLEN-1:0]          rs1_i;
  logic [XLEN-1:0]          rs2_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [XLEN-1:0]          wb_result_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;

  modport master (
    output issue_valid_i, op_i, word_i, rs1_i, rs2_i, trans_id_i, wb_ready_i,
    input  issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o
  );

  modport slave (
    input  issue_valid_i, op_i, word_i, rs1_i, rs2_i, trans_id_i, wb_ready_i,
    output issue_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o
  );
endinterface

// File: rtl/addx_accel_fu.sv
// ADDX shift-add functional unit: S1 operand capture, S2 compute, FIFO plus output slot.
// A credit counter bounds ops in flight so the pipeline never stalls internally.
module addx_accel_fu #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  addx_accel_fu_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [XLEN-1:0]          result;
  } entry_t;

  logic [CNT_W-1:0]         inflight_q;
  logic [CNT_W-1:0]         mem_cnt_q;
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  entry_t                   mem_q [FIFO_DEPTH];

  logic                     s1_v_q;
  logic [1:0]               s1_op_q;
  logic                     s1_word_q;
  logic [XLEN-1:0]          s1_rs1_q;
  logic [XLEN-1:0]          s1_rs2_q;
  logic [TRANS_ID_BITS-1:0] s1_id_q;

  logic                     s2_v_q;
  entry_t                   s2_q;

  logic                     out_v_q;
  entry_t                   out_q;

  logic                     accept;
  logic                     pop;
  logic                     push;
  logic                     mem_pop;
  logic [31:0]              sum_word;
  logic [XLEN-1:0]          sum_full;
  logic [XLEN-1:0]          s2_result;

  // Credit check only looks at registered state and flush, never at issue_valid_i.
  assign bus.issue_ready_o = (inflight_q < CNT_W'(FIFO_DEPTH)) & ~flush_i;
  assign accept            = bus.issue_valid_i & bus.issue_ready_o;
  assign pop               = out_v_q & bus.wb_ready_i;
  assign push              = s2_v_q;
  // The output slot refills from the FIFO whenever it is empty or being consumed.
  assign mem_pop           = (|mem_cnt_q) & (~out_v_q | pop);

  assign bus.wb_valid_o    = out_v_q;
  assign bus.wb_result_o   = out_q.result;
  assign bus.wb_trans_id_o = out_q.id;

  // Shift-add on the captured operands; word ops use the low half and sign-extend.
  always_comb begin
    sum_full = (s1_rs1_q << s1_op_q) + s1_rs2_q;
    sum_word = (s1_rs1_q[31:0] << s1_op_q) + s1_rs2_q[31:0];
    if (s1_word_q) begin
      s2_result = {{(XLEN-32){sum_word[31]}}, sum_word};
    end else begin
      s2_result = sum_full;
    end
  end

  // Control state: valids, pointers, counts.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      out_v_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
    end else if (flush_i) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      out_v_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= '0;
    end else begin
      s1_v_q     <= accept;
      s2_v_q     <= s1_v_q;
      inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(pop);
      mem_cnt_q  <= mem_cnt_q + CNT_W'(push) - CNT_W'(mem_pop);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (mem_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        out_v_q  <= 1'b1;
      end else if (pop) begin
        out_v_q  <= 1'b0;
      end
    end
  end

  // Datapath registers; cleared only by reset, flush just invalidates them.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_op_q   <= '0;
      s1_word_q <= 1'b0;
      s1_rs1_q  <= '0;
      s1_rs2_q  <= '0;
      s1_id_q   <= '0;
      s2_q      <= '0;
      out_q     <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        s1_op_q   <= bus.op_i;
        s1_word_q <= bus.word_i;
        s1_rs1_q  <= bus.rs1_i;
        s1_rs2_q  <= bus.rs2_i;
        s1_id_q   <= bus.trans_id_i;
      end
      if (s1_v_q) begin
        s2_q.result <= s2_result;
        s2_q.id     <= s1_id_q;
      end
      if (push && !flush_i) begin
        mem_q[wr_ptr_q] <= s2_q;
      end
      if (mem_pop && !flush_i) begin
        out_q <= mem_q[rd_ptr_q];
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (push & ~mem_pop) |-> (mem_cnt_q < CNT_W'(FIFO_DEPTH)));

  a_inflight_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q <= CNT_W'(FIFO_DEPTH));

  a_wb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.wb_valid_o & ~bus.wb_ready_i & ~flush_i) |=>
    (bus.wb_valid_o & $stable(bus.wb_result_o) & $stable(bus.wb_trans_id_o)));
endmodule

// File: tb/tb_addx_accel_fu.sv
// Self-checking bench for addx_accel_fu: directed cases then random traffic vs a queue model.
module tb_addx_accel_fu;
  logic clk;
  logic rst_n;
  logic flush;

  addx_accel_fu_if #(.XLEN(64), .TRANS_ID_BITS(3)) bus ();

  addx_accel_fu #(.XLEN(64), .TRANS_ID_BITS(3), .FIFO_DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  id;
    int          acc_e;
  } exp_t;

  exp_t        q[$];
  logic [2:0]  popped_ids[$];
  int          checks   = 0;
  int          passed   = 0;
  int          fails    = 0;
  int          now      = 0;
  int          last_pop = 0;
  int          acc_cnt  = 0;
  int          pop_cnt  = 0;
  int          lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: rs1 scaled by 2^op plus rs2, in 64 or 32 bits.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0] full;
    logic [31:0] low;
    full = a * (64'd1 << op) + b;
    low  = a[31:0] * (32'd1 << op) + b[31:0];
    if (w) return {{32{low[31]}}, low};
    return full;
  endfunction

  // One clock: check outputs against the model, update it, advance to the next negedge.
  task automatic cycle();
    logic exp_ready;
    logic exp_valid;
    logic acc;
    int   vis;
    #1;
    exp_ready = (q.size() < 4) && !flush;
    exp_valid = 1'b0;
    if (q.size() > 0) begin
      vis = (q[0].acc_e + 3 > last_pop) ? q[0].acc_e + 3 : last_pop;
      exp_valid = (now >= vis);
    end
    chk("issue_ready", 64'(bus.issue_ready_o), 64'(exp_ready));
    chk("wb_valid", 64'(bus.wb_valid_o), 64'(exp_valid));
    if (exp_valid && bus.wb_valid_o) begin
      chk("wb_result", bus.wb_result_o, q[0].res);
      chk("wb_trans_id", 64'(bus.wb_trans_id_o), 64'(q[0].id));
    end
    acc = bus.issue_valid_i && exp_ready;
    if (exp_valid && bus.wb_ready_i) begin
      popped_ids.push_back(bus.wb_trans_id_o);
      void'(q.pop_front());
      last_pop = now + 1;
      pop_cnt++;
    end
    if (!rst_n || flush) begin
      q.delete();
      last_pop = 0;
    end else if (acc) begin
      q.push_back('{res: ref_result(bus.op_i, bus.word_i, bus.rs1_i, bus.rs2_i),
                    id: bus.trans_id_i, acc_e: now + 1});
      acc_cnt++;
    end
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [2:0] id);
    bus.issue_valid_i = 1'b1;
    bus.op_i          = op;
    bus.word_i        = w;
    bus.rs1_i         = a;
    bus.rs2_i         = b;
    bus.trans_id_i    = id;
  endtask

  task automatic idle(input int n);
    bus.issue_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Issue one op into an empty unit and check its result and latency.
  task automatic run_one(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [2:0] id,
                         input logic [63:0] exp);
    bus.wb_ready_i = 1'b1;
    drive(op, w, a, b, id);
    cycle();
    bus.issue_valid_i = 1'b0;
    lat = 0;
    while (!bus.wb_valid_o && lat < 10) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd3);
    chk({tag, "_result"}, bus.wb_result_o, exp);
    chk({tag, "_id"}, 64'(bus.wb_trans_id_o), 64'(id));
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.issue_valid_i = 1'b0;
    bus.op_i = '0;
    bus.word_i = 1'b0;
    bus.rs1_i = '0;
    bus.rs2_i = '0;
    bus.trans_id_i = '0;
    bus.wb_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst_wb_result", bus.wb_result_o, 64'd0);
    chk("rst_wb_id", 64'(bus.wb_trans_id_o), 64'd0);
    chk("rst_ready", 64'(bus.issue_ready_o), 64'd1);
    @(negedge clk);

    run_one("add", 2'b00, 1'b0, 64'd5, 64'd7, 3'd2, 64'd12);
    run_one("sh3add", 2'b11, 1'b0, 64'h1, 64'h10, 3'd5, 64'h18);
    run_one("addw", 2'b00, 1'b1, 64'h7FFF_FFFF, 64'h1, 3'd1, 64'hFFFF_FFFF_8000_0000);
    run_one("wrap", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd6, 64'h0);

    // Backpressure: offer ids 0..5 back-to-back with writeback stalled.
    bus.wb_ready_i = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'(i));
      cycle();
    end
    chk("bp_accepted", 64'(acc_cnt), 64'd4);
    idle(4);
    chk("bp_ready_low", 64'(bus.issue_ready_o), 64'd0);
    popped_ids.delete();
    bus.wb_ready_i = 1'b1;
    idle(8);
    chk("bp_pop_count", 64'(popped_ids.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped_ids.size(); i++) begin
      chk("bp_order", 64'(popped_ids[i]), 64'(i));
    end

    // Full FIFO, then issue and pop together as credit frees.
    bus.wb_ready_i = 1'b0;
    acc_cnt = 0;
    pop_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'(i));
      cycle();
    end
    bus.wb_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(2'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 3'(i));
      cycle();
    end
    idle(10);
    chk("sim_no_loss", 64'(pop_cnt), 64'(acc_cnt));

    // Flush with three ops in flight.
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 1'b0, 64'(i), 64'd100, 3'(i));
      cycle();
    end
    flush = 1'b1;
    drive(2'b00, 1'b0, 64'd1, 64'd1, 3'd7);
    cycle();
    flush = 1'b0;
    bus.issue_valid_i = 1'b0;
    #1;
    chk("flush_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("flush_ready", 64'(bus.issue_ready_o), 64'd1);
    @(negedge clk);
    bus.wb_ready_i = 1'b1;
    idle(8);

    // Reset with two results queued.
    bus.wb_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(2'b10, 1'b0, 64'h55, 64'(i), 3'(i + 3));
      cycle();
    end
    idle(5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    chk("rst2_wb_valid", 64'(bus.wb_valid_o), 64'd0);
    chk("rst2_wb_result", bus.wb_result_o, 64'd0);
    chk("rst2_wb_id", 64'(bus.wb_trans_id_o), 64'd0);
    chk("rst2_ready", 64'(bus.issue_ready_o), 64'd1);
    @(negedge clk);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bus.issue_valid_i = ($urandom_range(0, 2) != 0);
      bus.op_i          = 2'($urandom);
      bus.word_i        = 1'($urandom);
      bus.rs1_i         = {$urandom, $urandom};
      bus.rs2_i         = {$urandom, $urandom};
      bus.trans_id_i    = 3'($urandom);
      bus.wb_ready_i    = ($urandom_range(0, 3) != 0);
      flush             = ($urandom_range(0, 39) == 0);
      cycle();
    end
    flush = 1'b0;
    bus.wb_ready_i = 1'b1;
    idle(12);
    chk("drain_wb_valid", 64'(bus.wb_valid_o), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
